// File: rtl/gps_pkt_rx_pkg.sv
// ============================================================================
// Module   : gps_pkt_rx_pkg
// Brief    : Shared constants, state encoding and range helper for gps_pkt_rx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gps_pkt_rx_pkg;

    localparam logic [7:0] C_SYNC_BYTE    = 8'hA5;
    localparam int         C_PAYLOAD_LEN  = 6;
    localparam int         C_COORD_W      = 24;
    localparam int         C_INT_W        = 8;
    localparam int         C_FRAC_W       = 16;
    localparam int         C_WAIT_W       = 10;
    localparam logic [7:0] C_LAT_MAX      = 8'd89;
    localparam logic [7:0] C_LON_MAX      = 8'd179;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CKSUM   = 2'd2,
        ST_WAIT    = 2'd3
    } state_t;

    // Integer-degree bytes only; the 16-bit fraction cannot push a value over.
    function automatic logic coord_in_range(input logic [C_INT_W-1:0] lon_int,
                                            input logic [C_INT_W-1:0] lat_int);
        return (lon_int <= C_LON_MAX) && (lat_int <= C_LAT_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/gps_pkt_rx_if.sv
// ============================================================================
// Module   : gps_pkt_rx_if
// Brief    : Byte-stream input and calculator-side point output of gps_pkt_rx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gps_pkt_rx_if;

    logic                                 byte_vld;
    logic [7:0]                           byte_data;
    logic                                 byte_rdy;
    logic                                 done_in;
    logic                                 DEN;
    logic [gps_pkt_rx_pkg::C_COORD_W-1:0] LON_OUT;
    logic [gps_pkt_rx_pkg::C_COORD_W-1:0] LAT_OUT;

    modport master (
        output byte_vld, byte_data, done_in,
        input  byte_rdy, DEN, LON_OUT, LAT_OUT
    );

    modport slave (
        input  byte_vld, byte_data, done_in,
        output byte_rdy, DEN, LON_OUT, LAT_OUT
    );

endinterface

`default_nettype wire

// File: rtl/gps_pkt_rx_sat_cnt.sv
// ============================================================================
// Module   : gps_sat_cnt
// Brief    : Saturating up-counter used for the good/reject packet statistics.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gps_sat_cnt #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             inc,
    output logic [WIDTH-1:0]      count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/gps_pkt_rx.sv
// ============================================================================
// Module   : gps_pkt_rx
// Brief    : Sync-hunting GPS point receiver with XOR checksum and DEN pacing.
//            Optional macro GPS_RANGE_CHECK_EN rejects out-of-range degrees.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gps_pkt_rx
    import gps_pkt_rx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = C_SYNC_BYTE,
    parameter int         FIRST_GAP = 160,
    parameter int         TIMEOUT   = 1023
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    gps_pkt_rx_if.slave      bus,
    output logic [7:0]       pkt_cnt,
    output logic [7:0]       err_cnt,
    output logic             tmo_err
);

    localparam logic [C_WAIT_W-1:0] c_gap_last = C_WAIT_W'(FIRST_GAP - 1);
    localparam logic [C_WAIT_W-1:0] c_tmo_last = C_WAIT_W'(TIMEOUT - 1);
    localparam logic [2:0]          c_idx_last = 3'(C_PAYLOAD_LEN - 1);

    state_t                       r_state;
    logic [2:0]                   r_idx;
    logic [7:0]                   r_chk;
    logic [2*C_COORD_W-1:0]       r_shreg;
    logic                         r_first_pt;
    logic [C_WAIT_W-1:0]          r_wait_cnt;
    logic                         r_den;
    logic                         r_rdy;
    logic                         r_tmo;
    logic [C_COORD_W-1:0]         r_lon;
    logic [C_COORD_W-1:0]         r_lat;

    logic                         w_accept;
    logic                         w_range_ok;
    logic                         w_good;
    logic                         w_pkt_inc;
    logic                         w_err_inc;

    assign w_accept = bus.byte_vld && r_rdy;

`ifdef GPS_RANGE_CHECK_EN
    assign w_range_ok = coord_in_range(r_shreg[2*C_COORD_W-1 -: C_INT_W],
                                       r_shreg[C_COORD_W-1 -: C_INT_W]);
`else
    assign w_range_ok = 1'b1;
`endif

    assign w_good    = (bus.byte_data == r_chk) && w_range_ok;
    assign w_pkt_inc = (r_state == ST_CKSUM) && w_accept && w_good;
    assign w_err_inc = (r_state == ST_CKSUM) && w_accept && !w_good;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_chk      <= '0;
            r_shreg    <= '0;
            r_first_pt <= 1'b1;
            r_wait_cnt <= '0;
            r_den      <= 1'b0;
            r_rdy      <= 1'b0;
            r_tmo      <= 1'b0;
            r_lon      <= '0;
            r_lat      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_rdy <= 1'b1;
                    if (w_accept && (bus.byte_data == SYNC_BYTE)) begin
                        r_idx   <= '0;
                        r_chk   <= '0;
                        r_state <= ST_PAYLOAD;
                    end
                end

                // A sync-valued byte here is ordinary payload; no resync.
                ST_PAYLOAD: begin
                    if (w_accept) begin
                        r_shreg <= {r_shreg[2*C_COORD_W-9:0], bus.byte_data};
                        r_chk   <= r_chk ^ bus.byte_data;
                        r_idx   <= r_idx + 1'b1;
                        if (r_idx == c_idx_last) begin
                            r_state <= ST_CKSUM;
                        end
                    end
                end

                ST_CKSUM: begin
                    if (w_accept) begin
                        if (w_good) begin
                            r_lon      <= r_shreg[2*C_COORD_W-1:C_COORD_W];
                            r_lat      <= r_shreg[C_COORD_W-1:0];
                            r_den      <= 1'b1;
                            r_rdy      <= 1'b0;
                            r_wait_cnt <= '0;
                            r_state    <= ST_WAIT;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end

                ST_WAIT: begin
                    r_den <= 1'b0;
                    if (r_first_pt) begin
                        // First point: calculator scans its table and never signals done.
                        if (r_wait_cnt == c_gap_last) begin
                            r_first_pt <= 1'b0;
                            r_rdy      <= 1'b1;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 1'b1;
                        end
                    end else if (bus.done_in) begin
                        r_rdy   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (r_wait_cnt == c_tmo_last) begin
                        r_tmo   <= 1'b1;
                        r_rdy   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    gps_sat_cnt #(.WIDTH(8)) u_pkt_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_pkt_inc),
        .count   (pkt_cnt)
    );

    gps_sat_cnt #(.WIDTH(8)) u_err_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_err_inc),
        .count   (err_cnt)
    );

    assign bus.byte_rdy = r_rdy;
    assign bus.DEN      = r_den;
    assign bus.LON_OUT  = r_lon;
    assign bus.LAT_OUT  = r_lat;
    assign tmo_err      = r_tmo;

endmodule

`default_nettype wire
